// File: rtl/cardinal_nic_if.sv
// cardinal_nic_if
// Purpose: bundles the processor register-file access signals and the
// router local-port handshake signals of the cardinal NIC.
// Ports (as interface signals):
//   nic_addr, d_in, nicEn, nicWrEn  processor -> NIC register access
//   d_out                           NIC -> processor read data
//   net_si, net_di                  router -> NIC input channel
//   net_ri                          NIC input channel ready
//   net_so, net_do                  NIC -> router output channel
//   net_ro, net_polarity            router ready and current VC phase
// Modports:
//   slave  - the NIC itself
//   master - the processor/router environment driving the NIC
interface cardinal_nic_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3
);
  logic [0:ADDR_WIDTH-1] nic_addr;
  logic [0:DATA_WIDTH-1] d_in;
  logic [0:DATA_WIDTH-1] d_out;
  logic                  nicEn;
  logic                  nicWrEn;
  logic                  net_si;
  logic                  net_ri;
  logic [0:DATA_WIDTH-1] net_di;
  logic                  net_so;
  logic                  net_ro;
  logic [0:DATA_WIDTH-1] net_do;
  logic                  net_polarity;

  modport slave (
    input  nic_addr, d_in, nicEn, nicWrEn,
    input  net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );

  modport master (
    output nic_addr, d_in, nicEn, nicWrEn,
    output net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/cardinal_nic.sv
// cardinal_nic
// Purpose: network interface between the cardinal processor and one router
// local port. Holds a single-entry input buffer (router -> processor) and a
// single-entry output buffer (processor -> router), each with a full flag.
// The processor sees them as a small register file:
//   0 input buffer (read, draining), 1 input status, 2 output buffer (write),
//   3 output status, 4-7 reserved (read 0, writes ignored).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low clear of all state
//   nic    cardinal_nic_if.slave bundle (processor access + router handshake)
// Packets and data use big-endian [0:DATA_WIDTH-1] numbering; VC_BIT selects
// the virtual-channel bit inside an outgoing packet.
module cardinal_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3,
  parameter int VC_BIT     = 0
) (
  input logic          clk,
  input logic          reset,
  cardinal_nic_if.slave nic
);

  localparam logic [0:ADDR_WIDTH-1] ADDR_IN_BUF  = ADDR_WIDTH'(0);
  localparam logic [0:ADDR_WIDTH-1] ADDR_IN_STS  = ADDR_WIDTH'(1);
  localparam logic [0:ADDR_WIDTH-1] ADDR_OUT_BUF = ADDR_WIDTH'(2);
  localparam logic [0:ADDR_WIDTH-1] ADDR_OUT_STS = ADDR_WIDTH'(3);

  logic [0:DATA_WIDTH-1] in_buf;
  logic                  in_full;
  logic [0:DATA_WIDTH-1] out_buf;
  logic                  out_full;

  logic rd_en;
  logic wr_en;
  logic in_fill;
  logic in_drain;
  logic out_load;
  logic out_inject;

  assign rd_en = nic.nicEn & ~nic.nicWrEn;
  assign wr_en = nic.nicEn &  nic.nicWrEn;

  // A full input buffer refuses new packets, so fill and drain never coincide.
  assign in_fill  = nic.net_si & ~in_full;
  assign in_drain = rd_en & (nic.nic_addr == ADDR_IN_BUF) & in_full;

  // The packet may only leave on the VC the router is not forwarding right now.
  assign out_load   = wr_en & (nic.nic_addr == ADDR_OUT_BUF) & ~out_full;
  assign out_inject = out_full & nic.net_ro & (out_buf[VC_BIT] == ~nic.net_polarity);

  // Input channel: capture on fill, release the flag when the processor
  // reads the buffer; the data itself is kept so later reads see it stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf  <= '0;
      in_full <= 1'b0;
    end else if (in_fill) begin
      in_buf  <= nic.net_di;
      in_full <= 1'b1;
    end else if (in_drain) begin
      in_full <= 1'b0;
    end
  end

  // Output channel: a write only lands when the buffer was empty at the
  // start of the cycle, so a write racing an injection is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
    end else if (out_load) begin
      out_buf  <= nic.d_in;
      out_full <= 1'b1;
    end else if (out_inject) begin
      out_full <= 1'b0;
    end
  end

  // Combinational register-file read; status flags sit in the LSB.
  always_comb begin
    nic.d_out = '0;
    if (rd_en) begin
      case (nic.nic_addr)
        ADDR_IN_BUF:  nic.d_out = in_buf;
        ADDR_IN_STS:  nic.d_out[DATA_WIDTH-1] = in_full;
        ADDR_OUT_STS: nic.d_out[DATA_WIDTH-1] = out_full;
        default:      nic.d_out = '0;
      endcase
    end
  end

  assign nic.net_ri = ~in_full;
  assign nic.net_so = out_inject;
  assign nic.net_do = out_buf;

endmodule

// File: tb/tb_cardinal_nic.sv
// tb_cardinal_nic
// Purpose: directed self-checking bench for cardinal_nic. Inputs change on
// the falling clock edge and outputs are compared shortly after, well away
// from the rising edge where state updates.
module tb_cardinal_nic;

  localparam int DW = 64;
  localparam int AW = 3;

  logic clk;
  logic reset;
  int   compareCount;
  int   failCount;

  cardinal_nic_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cardinal_nic #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VC_BIT(0)) dut (
    .clk   (clk),
    .reset (reset),
    .nic   (bus.slave)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drives every NIC input for the current cycle, then lets logic settle.
  task automatic applyStimulus(input logic en, input logic wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] din,
                               input logic si, input logic [DW-1:0] di,
                               input logic ro, input logic pol);
    bus.nicEn        = en;
    bus.nicWrEn      = wr;
    bus.nic_addr     = addr;
    bus.d_in         = din;
    bus.net_si       = si;
    bus.net_di       = di;
    bus.net_ro       = ro;
    bus.net_polarity = pol;
    #1;
  endtask

  // Advance through one rising edge and back to the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    compareCount = 0;
    failCount    = 0;
    reset        = 1'b0;
    applyStimulus(0, 0, 0, '0, 0, '0, 0, 0);

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_d_out",  bus.d_out,  64'd0);
    checkOutput("rst_net_so", 64'(bus.net_so), 64'd0);
    checkOutput("rst_net_ri", 64'(bus.net_ri), 64'd1);
    checkOutput("rst_net_do", bus.net_do, 64'd0);
    reset = 1'b1;
    applyStimulus(1, 0, 1, '0, 0, '0, 0, 0);
    checkOutput("rst_in_sts", bus.d_out, 64'd0);
    applyStimulus(1, 0, 3, '0, 0, '0, 0, 0);
    checkOutput("rst_out_sts", bus.d_out, 64'd0);

    // Input channel fill and drain
    applyStimulus(0, 0, 0, '0, 1, 64'hDEAD_BEEF_0000_0001, 0, 0);
    checkOutput("in_ri_before", 64'(bus.net_ri), 64'd1);
    tick();
    applyStimulus(1, 0, 1, '0, 0, '0, 0, 0);
    checkOutput("in_ri_full", 64'(bus.net_ri), 64'd0);
    checkOutput("in_sts_full", bus.d_out, 64'd1);
    applyStimulus(1, 0, 0, '0, 0, '0, 0, 0);
    checkOutput("in_buf_read", bus.d_out, 64'hDEAD_BEEF_0000_0001);
    tick();
    applyStimulus(1, 0, 1, '0, 0, '0, 0, 0);
    checkOutput("in_sts_drained", bus.d_out, 64'd0);
    checkOutput("in_ri_drained", 64'(bus.net_ri), 64'd1);
    applyStimulus(1, 0, 0, '0, 0, '0, 0, 0);
    checkOutput("in_buf_stale", bus.d_out, 64'hDEAD_BEEF_0000_0001);
    tick();
    applyStimulus(1, 0, 1, '0, 0, '0, 0, 0);
    checkOutput("in_stale_noeffect", bus.d_out, 64'd0);

    // Output channel: VC polarity gating
    applyStimulus(1, 1, 2, 64'h8000_0000_0000_00AA, 0, '0, 1, 1);
    checkOutput("out_so_empty", 64'(bus.net_so), 64'd0);
    tick();
    applyStimulus(1, 0, 3, '0, 0, '0, 1, 1);
    checkOutput("out_sts_full", bus.d_out, 64'd1);
    checkOutput("out_so_wrongvc", 64'(bus.net_so), 64'd0);
    tick();
    applyStimulus(0, 0, 0, '0, 0, '0, 1, 0);
    checkOutput("out_so_vc", 64'(bus.net_so), 64'd1);
    checkOutput("out_do_vc", bus.net_do, 64'h8000_0000_0000_00AA);
    tick();
    applyStimulus(1, 0, 3, '0, 0, '0, 1, 0);
    checkOutput("out_so_once", 64'(bus.net_so), 64'd0);
    checkOutput("out_sts_sent", bus.d_out, 64'd0);

    // Router not ready; a second write must not overwrite the held packet
    applyStimulus(1, 1, 2, 64'h0000_0000_0000_0055, 0, '0, 0, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) applyStimulus(1, 1, 2, 64'h1234, 0, '0, 0, 1);
      else        applyStimulus(0, 0, 0, '0, 0, '0, 0, 1);
      checkOutput($sformatf("out_so_notready_%0d", i), 64'(bus.net_so), 64'd0);
      tick();
    end
    applyStimulus(0, 0, 0, '0, 0, '0, 1, 1);
    checkOutput("out_so_ready", 64'(bus.net_so), 64'd1);
    checkOutput("out_do_kept", bus.net_do, 64'h0000_0000_0000_0055);
    tick();
    applyStimulus(1, 0, 3, '0, 0, '0, 1, 1);
    checkOutput("out_sts_after_ready", bus.d_out, 64'd0);

    // One-cycle write-to-send latency; a write during the drain is dropped
    applyStimulus(1, 1, 2, 64'h8000_0000_0000_00BB, 0, '0, 1, 0);
    tick();
    applyStimulus(1, 1, 2, 64'h77, 0, '0, 1, 0);
    checkOutput("lat_so", 64'(bus.net_so), 64'd1);
    checkOutput("lat_do", bus.net_do, 64'h8000_0000_0000_00BB);
    tick();
    applyStimulus(1, 0, 3, '0, 0, '0, 1, 0);
    checkOutput("race_sts", bus.d_out, 64'd0);
    checkOutput("race_so", 64'(bus.net_so), 64'd0);
    checkOutput("race_do", bus.net_do, 64'h8000_0000_0000_00BB);

    // Input overrun, disabled access, reserved addresses
    applyStimulus(0, 0, 0, '0, 1, 64'hCAFE, 0, 0);
    tick();
    applyStimulus(0, 0, 0, '0, 1, 64'hFFFF, 0, 0);
    checkOutput("ovr_ri", 64'(bus.net_ri), 64'd0);
    tick();
    applyStimulus(0, 0, 0, '0, 0, '0, 0, 0);
    checkOutput("dis_d_out", bus.d_out, 64'd0);
    tick();
    applyStimulus(1, 1, 6, 64'hFFFF_FFFF_FFFF_FFFF, 0, '0, 0, 0);
    checkOutput("dis_no_drain", 64'(bus.net_ri), 64'd0);
    tick();
    applyStimulus(1, 0, 5, '0, 0, '0, 0, 0);
    checkOutput("rsv5_read", bus.d_out, 64'd0);
    applyStimulus(1, 0, 3, '0, 0, '0, 0, 0);
    checkOutput("rsv6_write_ignored", bus.d_out, 64'd0);
    applyStimulus(1, 0, 0, '0, 0, '0, 0, 0);
    checkOutput("ovr_buf_kept", bus.d_out, 64'hCAFE);
    tick();
    applyStimulus(0, 0, 0, '0, 1, 64'h99, 0, 0);
    checkOutput("refill_ri", 64'(bus.net_ri), 64'd1);
    tick();
    applyStimulus(1, 0, 0, '0, 0, '0, 0, 0);
    checkOutput("refill_buf", bus.d_out, 64'h99);
    tick();

    // Asynchronous reset mid-cycle with both buffers full
    applyStimulus(1, 1, 2, 64'h8000_0000_0000_00CC, 1, 64'h42, 0, 0);
    tick();
    applyStimulus(0, 0, 0, '0, 0, '0, 1, 0);
    checkOutput("arst_so_before", 64'(bus.net_so), 64'd1);
    checkOutput("arst_ri_before", 64'(bus.net_ri), 64'd0);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("arst_so", 64'(bus.net_so), 64'd0);
    checkOutput("arst_do", bus.net_do, 64'd0);
    checkOutput("arst_ri", 64'(bus.net_ri), 64'd1);
    applyStimulus(1, 0, 3, '0, 0, '0, 1, 0);
    checkOutput("arst_out_sts", bus.d_out, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
